// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard action decoder.
// Contents: the receiver state enum, the scancode constants, the action bit
// indices and the scancode-to-action lookup used by the decoder.
package ps2_pkg;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  localparam logic [7:0] SC_EXT       = 8'hE0;
  localparam logic [7:0] SC_BRK       = 8'hF0;
  localparam logic [7:0] SC_RIGHT_EXT = 8'h74;
  localparam logic [7:0] SC_LEFT_EXT  = 8'h6B;
  localparam logic [7:0] SC_ROT_EXT   = 8'h75;
  localparam logic [7:0] SC_RIGHT     = 8'h23;  // 'D'
  localparam logic [7:0] SC_LEFT      = 8'h1C;  // 'A'
  localparam logic [7:0] SC_ROT       = 8'h1D;  // 'W'

  localparam int ACT_RIGHT = 0;
  localparam int ACT_LEFT  = 1;
  localparam int ACT_ROT   = 2;

  // One-hot action for a scancode; zero for unmapped codes. Extended codes
  // only match when the E0 prefix was seen, plain codes only when it was not.
  function automatic logic [2:0] sc_lookup(input logic [7:0] code,
                                           input logic       ext);
    logic [2:0] act;
    act = '0;
    if (ext) begin
      if (code == SC_RIGHT_EXT) act[ACT_RIGHT] = 1'b1;
      if (code == SC_LEFT_EXT)  act[ACT_LEFT]  = 1'b1;
      if (code == SC_ROT_EXT)   act[ACT_ROT]   = 1'b1;
    end else begin
      if (code == SC_RIGHT) act[ACT_RIGHT] = 1'b1;
      if (code == SC_LEFT)  act[ACT_LEFT]  = 1'b1;
      if (code == SC_ROT)   act[ACT_ROT]   = 1'b1;
    end
    return act;
  endfunction

endpackage

// File: rtl/ps2_action_decoder_rx.sv
// PS/2 frame receiver: input synchronizers, falling-edge detect, the
// start/data/parity/stop FSM and the inter-edge timeout.
// Ports:
//   clk_i, rst_ni           system clock, async active-low reset
//   ps2_clk_i, ps2_data_i   raw PS/2 lines (asynchronous)
//   byte_valid_o            1-cycle pulse, frame received with good parity/stop
//   byte_data_o[7:0]        received byte, valid with byte_valid_o
//   frame_error_o           1-cycle pulse on parity, stop or timeout error
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_error_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;

  rx_state_e              state_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             shift_q;
  logic                   par_ok_q;
  logic                   byte_valid_q;
  logic                   frame_err_q;
  logic [TW-1:0]          tmo_q;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q & ~clk_s;

  // Chains reset to 1 so that reset release never looks like a falling edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      clk_prev_q  <= clk_s;
    end
  end

  // Frame FSM. A falling edge takes priority over the timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= RX_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_ok_q     <= 1'b0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      tmo_q        <= '0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (fall) begin
        tmo_q <= '0;
        case (state_q)
          RX_IDLE: begin
            if (!data_s) begin
              state_q   <= RX_DATA;
              bit_cnt_q <= '0;
            end
          end
          RX_DATA: begin
            shift_q   <= {data_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= RX_PARITY;
          end
          RX_PARITY: begin
            par_ok_q <= ^{shift_q, data_s};
            state_q  <= RX_STOP;
          end
          RX_STOP: begin
            if (data_s && par_ok_q) byte_valid_q <= 1'b1;
            else                    frame_err_q  <= 1'b1;
            state_q <= RX_IDLE;
          end
          default: state_q <= RX_IDLE;
        endcase
      end else if (state_q == RX_IDLE) begin
        tmo_q <= '0;
      end else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
        state_q     <= RX_IDLE;
        frame_err_q <= 1'b1;
        tmo_q       <= '0;
      end else begin
        tmo_q <= tmo_q + TW'(1);
      end
    end
  end

  assign byte_valid_o  = byte_valid_q;
  assign byte_data_o   = shift_q;
  assign frame_error_o = frame_err_q;

endmodule

// File: rtl/ps2_action_decoder.sv
// PS/2 keyboard to game action decoder.
// Receives scancodes through ps2_rx and turns make/break codes for the
// right, left and rotate keys into press pulses and held levels.
// Ports:
//   clock, reset_n        system clock, async active-low reset
//   ps2_clk, ps2_data     raw PS/2 lines
//   actions[2:0]          1-cycle press pulses (0 right, 1 left, 2 rotate)
//   held[2:0]             key-down levels, same mapping
//   frame_error           1-cycle pulse on any receive error
module ps2_action_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [2:0] actions,
  output logic [2:0] held,
  output logic       frame_error
);

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_err;

  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [2:0] held_q, held_d;
  logic [2:0] actions_q, actions_d;
  logic       ferr_q, ferr_d;
  logic [2:0] hit;

  ps2_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_rx (
    .clk_i         (clock),
    .rst_ni        (reset_n),
    .ps2_clk_i     (ps2_clk),
    .ps2_data_i    (ps2_data),
    .byte_valid_o  (rx_valid),
    .byte_data_o   (rx_byte),
    .frame_error_o (rx_err)
  );

  // Prefix flags accumulate across bytes; any non-prefix byte or a receive
  // error ends the sequence. Breaks only release, makes pulse and hold.
  always_comb begin
    ext_d     = ext_q;
    brk_d     = brk_q;
    held_d    = held_q;
    actions_d = '0;
    ferr_d    = rx_err;
    hit       = sc_lookup(rx_byte, ext_q);
    if (rx_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid) begin
      case (rx_byte)
        SC_EXT:  ext_d = 1'b1;
        SC_BRK:  brk_d = 1'b1;
        default: begin
          if (brk_q) begin
            held_d = held_q & ~hit;
          end else begin
            actions_d = hit;
            held_d    = held_q | hit;
          end
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      held_q    <= '0;
      actions_q <= '0;
      ferr_q    <= 1'b0;
    end else begin
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      held_q    <= held_d;
      actions_q <= actions_d;
      ferr_q    <= ferr_d;
    end
  end

  assign actions     = actions_q;
  assign held        = held_q;
  assign frame_error = ferr_q;

endmodule

// File: tb/tb_ps2_action_decoder.sv
module tb_ps2_action_decoder;

  localparam int TMO = 200;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [2:0] actions;
  logic [2:0] held;
  logic       frame_error;

  int errors = 0;
  int checks = 0;

  // Monitor totals (only written by the monitor).
  int hi[3];
  int rises[3];
  int errs;
  int multi;
  logic [2:0] prev_act;

  // Snapshots (only written by the initial-block tasks).
  int b_hi[3];
  int b_rises[3];
  int b_errs;

  ps2_action_decoder #(
    .TIMEOUT_CYCLES (TMO),
    .SYNC_STAGES    (2)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .actions     (actions),
    .held        (held),
    .frame_error (frame_error)
  );

  always #5 clock = ~clock;

  initial begin
    for (int i = 0; i < 3; i++) begin
      hi[i] = 0;
      rises[i] = 0;
    end
    errs = 0;
    multi = 0;
    prev_act = '0;
  end

  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (actions[i] === 1'b1) hi[i] = hi[i] + 1;
      if (actions[i] === 1'b1 && prev_act[i] !== 1'b1) rises[i] = rises[i] + 1;
    end
    if (frame_error === 1'b1) errs = errs + 1;
    if ($countones(actions) > 1) multi = multi + 1;
    prev_act = actions;
  end

  task automatic snap();
    for (int i = 0; i < 3; i++) begin
      b_hi[i] = hi[i];
      b_rises[i] = rises[i];
    end
    b_errs = errs;
  endtask

  task automatic ps2_bit(input logic v);
    @(negedge clock);
    ps2_data = v;
    repeat (5) @(negedge clock);
    ps2_clk = 1'b0;
    repeat (10) @(negedge clock);
    ps2_clk = 1'b1;
    repeat (5) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    logic p;
    p = (~^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(p);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    repeat (20) @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (actions !== 3'b000) begin
      errors++; $display("FAIL reset_actions got=%b want=000", actions);
    end
    checks++;
    if (held !== 3'b000) begin
      errors++; $display("FAIL reset_held got=%b want=000", held);
    end
    checks++;
    if (frame_error !== 1'b0) begin
      errors++; $display("FAIL reset_frame_error got=%b want=0", frame_error);
    end
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
  endtask

  task automatic test_make();
    snap();
    send_byte(8'h1C, 1'b0);
    checks++;
    if (hi[1] - b_hi[1] !== 1) begin
      errors++; $display("FAIL make_left_width got=%0d want=1", hi[1] - b_hi[1]);
    end
    checks++;
    if ((hi[0] - b_hi[0]) + (hi[2] - b_hi[2]) !== 0) begin
      errors++; $display("FAIL make_other_bits got=%0d want=0", (hi[0] - b_hi[0]) + (hi[2] - b_hi[2]));
    end
    checks++;
    if (held !== 3'b010) begin
      errors++; $display("FAIL make_held got=%b want=010", held);
    end
  endtask

  task automatic test_ext();
    snap();
    send_byte(8'hE0, 1'b0);
    send_byte(8'h74, 1'b0);
    checks++;
    if (rises[0] - b_rises[0] !== 1 || hi[0] - b_hi[0] !== 1) begin
      errors++; $display("FAIL ext_right_pulse got=%0d/%0d want=1/1", rises[0] - b_rises[0], hi[0] - b_hi[0]);
    end
    checks++;
    if (held !== 3'b011) begin
      errors++; $display("FAIL ext_make_held got=%b want=011", held);
    end
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h74, 1'b0);
    checks++;
    if (hi[0] - b_hi[0] !== 1) begin
      errors++; $display("FAIL ext_break_no_pulse got=%0d want=1", hi[0] - b_hi[0]);
    end
    checks++;
    if (held !== 3'b010) begin
      errors++; $display("FAIL ext_break_held got=%b want=010", held);
    end
  endtask

  task automatic test_parity();
    snap();
    send_byte(8'h1D, 1'b1);
    checks++;
    if (errs - b_errs !== 1) begin
      errors++; $display("FAIL parity_err_pulses got=%0d want=1", errs - b_errs);
    end
    checks++;
    if ((hi[0] - b_hi[0]) + (hi[1] - b_hi[1]) + (hi[2] - b_hi[2]) !== 0) begin
      errors++; $display("FAIL parity_no_action got=%0d want=0", (hi[0] - b_hi[0]) + (hi[1] - b_hi[1]) + (hi[2] - b_hi[2]));
    end
    checks++;
    if (held !== 3'b010) begin
      errors++; $display("FAIL parity_held got=%b want=010", held);
    end
    send_byte(8'h1D, 1'b0);
    checks++;
    if (hi[2] - b_hi[2] !== 1) begin
      errors++; $display("FAIL parity_recover_rot got=%0d want=1", hi[2] - b_hi[2]);
    end
    checks++;
    if (held !== 3'b110) begin
      errors++; $display("FAIL parity_recover_held got=%b want=110", held);
    end
  endtask

  task automatic test_timeout();
    snap();
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_data = 1'b1;
    repeat (TMO + 60) @(negedge clock);
    checks++;
    if (errs - b_errs !== 1) begin
      errors++; $display("FAIL timeout_err_pulses got=%0d want=1", errs - b_errs);
    end
    send_byte(8'h23, 1'b0);
    checks++;
    if (hi[0] - b_hi[0] !== 1) begin
      errors++; $display("FAIL timeout_recover_right got=%0d want=1", hi[0] - b_hi[0]);
    end
    checks++;
    if (held !== 3'b111) begin
      errors++; $display("FAIL timeout_recover_held got=%b want=111", held);
    end
  endtask

  task automatic test_typematic();
    snap();
    for (int k = 0; k < 3; k++) begin
      send_byte(8'h23, 1'b0);
      checks++;
      if (held[0] !== 1'b1) begin
        errors++; $display("FAIL typematic_held_%0d got=%b want=1", k, held[0]);
      end
    end
    checks++;
    if (rises[0] - b_rises[0] !== 3 || hi[0] - b_hi[0] !== 3) begin
      errors++; $display("FAIL typematic_pulses got=%0d/%0d want=3/3", rises[0] - b_rises[0], hi[0] - b_hi[0]);
    end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h23, 1'b0);
    checks++;
    if (held !== 3'b110) begin
      errors++; $display("FAIL typematic_break_held got=%b want=110", held);
    end
  endtask

  task automatic test_reset_midframe();
    send_byte(8'hE0, 1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b0);
    ps2_data = 1'b1;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if (held !== 3'b000 || actions !== 3'b000 || frame_error !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs got=%b/%b/%b want=000/000/0", held, actions, frame_error);
    end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    snap();
    send_byte(8'h74, 1'b0);
    checks++;
    if ((hi[0] - b_hi[0]) + (hi[1] - b_hi[1]) + (hi[2] - b_hi[2]) !== 0) begin
      errors++; $display("FAIL midreset_lone_74 got=%0d want=0", (hi[0] - b_hi[0]) + (hi[1] - b_hi[1]) + (hi[2] - b_hi[2]));
    end
    checks++;
    if (held !== 3'b000) begin
      errors++; $display("FAIL midreset_held got=%b want=000", held);
    end
    send_byte(8'h1C, 1'b0);
    checks++;
    if (hi[1] - b_hi[1] !== 1 || held !== 3'b010) begin
      errors++; $display("FAIL midreset_live got=%0d/%b want=1/010", hi[1] - b_hi[1], held);
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_ext();
    test_parity();
    test_timeout();
    test_typematic();
    test_reset_midframe();
    checks++;
    if (multi !== 0) begin
      errors++; $display("FAIL onehot_actions got=%0d want=0", multi);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
